// File: rtl/jtframe_ddr_pkg.sv
// Shared definitions for the two-port DDR burst arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: DDR field widths, FSM state codes, eff_beats() mapping a
// zero burst length onto a single beat.
package jtframe_ddr_pkg;
  localparam int DDR_AW  = 29;  // word address, byte address bits [31:3]
  localparam int BURST_W = 8;
  localparam int DATA_W  = 64;
  localparam int BE_W    = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  function automatic logic [BURST_W-1:0] eff_beats(input logic [BURST_W-1:0] cnt);
    return (cnt == '0) ? BURST_W'(1) : cnt;
  endfunction
endpackage

// File: rtl/jtframe_ddr_arb2_if.sv
// Avalon-style DDR burst port bundle (request fields plus stall/read return).
// Latency: n/a (wires only).
// Backpressure: busy stalls the requester; dout_ready qualifies dout.
// master: drives addr/burstcnt/rd/we/din/be, receives busy/dout/dout_ready.
// slave : the opposite side.
interface jtframe_ddr_arb2_if #(parameter int AW = jtframe_ddr_pkg::DDR_AW);
  import jtframe_ddr_pkg::*;

  logic [AW-1:0]      addr;
  logic [BURST_W-1:0] burstcnt;
  logic               rd;
  logic               we;
  logic [DATA_W-1:0]  din;
  logic [BE_W-1:0]    be;
  logic               busy;
  logic [DATA_W-1:0]  dout;
  logic               dout_ready;

  modport master (output addr, burstcnt, rd, we, din, be,
                  input  busy, dout, dout_ready);
  modport slave  (input  addr, burstcnt, rd, we, din, be,
                  output busy, dout, dout_ready);
endinterface

// File: rtl/jtframe_ddr_arb2_mux.sv
// Selects one of two request bundles (addr/burstcnt/rd/we/din/be).
// Latency: purely combinational, zero cycles.
// Backpressure: none here; stall routing is done by the arbiter top.
// Ports: sel (0 = port 0, 1 = port 1), *0/*1 request fields, selected outputs.
module jtframe_ddr_arb2_mux
  import jtframe_ddr_pkg::*;
#(
  parameter int AW = DDR_AW
) (
  input  logic               sel,
  input  logic [AW-1:0]      addr0,
  input  logic [BURST_W-1:0] burstcnt0,
  input  logic               rd0,
  input  logic               we0,
  input  logic [DATA_W-1:0]  din0,
  input  logic [BE_W-1:0]    be0,
  input  logic [AW-1:0]      addr1,
  input  logic [BURST_W-1:0] burstcnt1,
  input  logic               rd1,
  input  logic               we1,
  input  logic [DATA_W-1:0]  din1,
  input  logic [BE_W-1:0]    be1,
  output logic [AW-1:0]      addr,
  output logic [BURST_W-1:0] burstcnt,
  output logic               rd,
  output logic               we,
  output logic [DATA_W-1:0]  din,
  output logic [BE_W-1:0]    be
);
  assign addr     = sel ? addr1     : addr0;
  assign burstcnt = sel ? burstcnt1 : burstcnt0;
  assign rd       = sel ? rd1       : rd0;
  assign we       = sel ? we1       : we0;
  assign din      = sel ? din1      : din0;
  assign be       = sel ? be1       : be0;
endmodule

// File: rtl/jtframe_ddr_arb2.sv
// Two-port arbiter sharing one DDR burst port; port 0 has priority, port 1 is
// protected from starvation. Grant is held for a whole burst.
// Latency: zero-cycle selection/pass-through in IDLE; st_dout one cycle.
// Backpressure: owner sees ddram.busy, the other port is held busy=1.
// Ports: clk, rst_n (sync, active-low), p0/p1 requester bundles (slave),
// ddram bundle towards DDR (master), st_addr/st_dout status readback.
module jtframe_ddr_arb2
  import jtframe_ddr_pkg::*;
#(
  parameter int STARVE = 4,
  parameter int AW     = DDR_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  jtframe_ddr_arb2_if.slave  p0,
  jtframe_ddr_arb2_if.slave  p1,
  jtframe_ddr_arb2_if.master ddram,
  input  logic [3:0]         st_addr,
  output logic [7:0]         st_dout
);
  localparam logic [3:0] STARVE_C = 4'(STARVE);

  logic [1:0]         state;
  logic               owner;
  logic [BURST_W-1:0] beats, rcnt, wcnt;
  logic [3:0]         starve_cnt;
  logic               err;

  logic               p0_req, p1_req, idle, sel, accept;
  logic [AW-1:0]      m_addr;
  logic [BURST_W-1:0] m_burstcnt;
  logic               m_rd, m_we;
  logic [DATA_W-1:0]  m_din;
  logic [BE_W-1:0]    m_be;

  assign p0_req = p0.rd | p0.we;
  assign p1_req = p1.rd | p1.we;
  assign idle   = (state == ST_IDLE);
  // Port 1 wins when port 0 is quiet or has had STARVE grants in a row.
  assign sel    = idle ? (p1_req & (~p0_req | (starve_cnt == STARVE_C))) : owner;

  jtframe_ddr_arb2_mux #(.AW(AW)) u_mux (
    .sel(sel),
    .addr0(p0.addr), .burstcnt0(p0.burstcnt), .rd0(p0.rd), .we0(p0.we), .din0(p0.din), .be0(p0.be),
    .addr1(p1.addr), .burstcnt1(p1.burstcnt), .rd1(p1.rd), .we1(p1.we), .din1(p1.din), .be1(p1.be),
    .addr(m_addr), .burstcnt(m_burstcnt), .rd(m_rd), .we(m_we), .din(m_din), .be(m_be)
  );

  assign accept = idle & (m_rd | m_we) & ~ddram.busy;

  assign ddram.addr     = m_addr;
  assign ddram.burstcnt = m_burstcnt;
  assign ddram.din      = m_din;
  assign ddram.be       = m_be;
  // Commands are only issued from IDLE (rd) or streamed in WRITE (we).
  // A simultaneous rd+we is issued as a read, so we is masked by rd in IDLE.
  assign ddram.rd = rst_n & idle & m_rd;
  assign ddram.we = rst_n & ((idle & m_we & ~m_rd) | ((state == ST_WRITE) & m_we));

  assign p0.busy = ~rst_n | sel  | ddram.busy;
  assign p1.busy = ~rst_n | ~sel | ddram.busy;

  assign p0.dout = ddram.dout;
  assign p1.dout = ddram.dout;
  // Read beats are routed only while a read burst is open, never in IDLE.
  assign p0.dout_ready = rst_n & (state == ST_READ) & ~owner & ddram.dout_ready;
  assign p1.dout_ready = rst_n & (state == ST_READ) &  owner & ddram.dout_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      beats      <= '0;
      rcnt       <= '0;
      wcnt       <= '0;
      starve_cnt <= '0;
      err        <= 1'b0;
      st_dout    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner <= sel;
            beats <= eff_beats(m_burstcnt);
            if ((m_burstcnt == '0) || (m_rd && m_we)) err <= 1'b1;
            if (m_rd) begin
              state <= ST_READ;
              rcnt  <= '0;
            end else begin
              // The first write beat goes out with the request itself.
              wcnt <= BURST_W'(1);
              if (eff_beats(m_burstcnt) != BURST_W'(1)) state <= ST_WRITE;
            end
          end
        end
        ST_READ: begin
          if (ddram.dout_ready) begin
            rcnt <= rcnt + BURST_W'(1);
            if (rcnt == beats - BURST_W'(1)) state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (m_we && !ddram.busy) begin
            wcnt <= wcnt + BURST_W'(1);
            if (wcnt + BURST_W'(1) == beats) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (!p1_req) starve_cnt <= '0;
      else if (accept && sel) starve_cnt <= '0;
      else if (accept && !sel && (starve_cnt != STARVE_C)) starve_cnt <= starve_cnt + 4'd1;

      case (st_addr)
        4'd0:    st_dout <= {err, owner, state, starve_cnt};
        4'd1:    st_dout <= beats;
        4'd2:    st_dout <= (state == ST_READ) ? rcnt : wcnt;
        default: st_dout <= '0;
      endcase
    end
  end
endmodule

// File: doc/jtframe_ddr_arb2.md
Name: jtframe_ddr_arb2

Overview:
Two-port arbiter that shares a single DDR burst port (Avalon-style: busy, burstcnt, rd/we, dout_ready) between the line frame-buffer controller (port 0, real-time) and a secondary requester (port 1, e.g. download/ROM loader).
- A grant is held for a whole burst.
- Port 0 has fixed priority; a starvation counter guarantees port 1 progress.
- Sits between the requesters and the top-level DDR interface.

Parameters:
STARVE, 4, number of consecutive port-0 grants while port 1 is pending, after which port 1 wins the next arbitration (1..15).
AW, 29, DDR word address width (bits [31:3]).

Ports:
clk  in  1  system clock; the only clock.
rst_n  in  1  reset, synchronous, active-low.
p0_addr  in  AW  port 0 burst start address.
p0_burstcnt  in  8  port 0 burst length.
p0_rd  in  1  port 0 read request.
p0_we  in  1  port 0 write request/beat valid.
p0_din  in  64  port 0 write data.
p0_be  in  8  port 0 byte enables.
p0_busy  out  1  port 0 stall.
p0_dout_ready  out  1  port 0 read beat valid.
p1_addr, p1_burstcnt, p1_rd, p1_we, p1_din, p1_be, p1_busy, p1_dout_ready: same as port 0, for port 1.
pX_dout  out  64  read data, ddram_dout broadcast to both ports.
ddram_addr  out  AW  DDR address.
ddram_burstcnt  out  8  DDR burst length.
ddram_rd  out  1  DDR read.
ddram_we  out  1  DDR write.
ddram_din  out  64  DDR write data.
ddram_be  out  8  DDR byte enables.
ddram_busy  in  1  DDR stall.
ddram_dout  in  64  DDR read data.
ddram_dout_ready  in  1  DDR read beat valid.
st_addr  in  4  status select.
st_dout  out  8  status byte, registered.

Behaviour:
- States: IDLE, READ, WRITE, plus a registered owner bit.
- IDLE, selection (combinational, zero latency):
  - sel = 1 if p1 requests (rd|we) and (p0 idle or starve_cnt==STARVE); otherwise sel = 0 if p0 requests.
  - The selected port's addr/burstcnt/rd/we/din/be drive ddram_* in the same cycle; the selected port's busy = ddram_busy.
  - The unselected port sees busy=1, and its requests never reach DDR.
- Acceptance = selected rd|we high while ddram_busy=0:
  - Latch owner=sel and beats=burstcnt (burstcnt 0 latched as 1 and sets sticky err bit).
  - rd -> READ with rcnt=0.
  - we -> WRITE with wcnt=1; if beats==1, stay in IDLE.
  - rd and we both high on one port: rd wins, we ignored, err set.
- READ:
  - Outputs forced from owner but ddram_rd forced 0; owner busy = ddram_busy; other busy=1.
  - Each ddram_dout_ready increments rcnt and pulses owner's dout_ready; the other port's dout_ready is always 0.
  - rcnt==beats-1 with a beat -> IDLE in the next cycle.
- WRITE:
  - Owner's we/din/be pass through, ddram_rd=0.
  - Each cycle with we=1 and ddram_busy=0 is one beat: wcnt++.
  - Last beat accepted -> IDLE; a new arbitration is allowed in the cycle after.
- starve_cnt:
  - Increments (saturating at STARVE) on each port-0 acceptance while port 1 has a pending request.
  - Clears on port-1 acceptance or when port 1 is not requesting.
- Owner changes only in IDLE; a requester dropping rd/we mid-burst does not release the grant.
- While rst_n=0 on the clock edge:
  - State=IDLE, counters=0, err=0, st_dout=0.
  - Outputs: ddram_rd=0, ddram_we=0, both busy=1, both dout_ready=0.
  - Reset mid-burst abandons the burst; DDR-side stray dout_ready after reset is ignored (IDLE routes none).
- st_dout registered by st_addr:
  - 0: {err, owner, state[1:0], starve_cnt[3:0]}
  - 1: beats
  - 2: rcnt or wcnt of the current state
  - others: 0.

Decomposition:
- Package jtframe_ddr_pkg: state encoding (IDLE/READ/WRITE), DDR port field widths (AW, 8-bit burst, 64-bit data, 8-bit BE).
- One natural sub-module, jtframe_ddr_arb2_mux: purely combinational owner/selection mux of the request bundle.
- The FSM, counters and status stay in the top module.

Test Plan:
1. p0 read burstcnt=128 with ddram_busy=0 and 128 dout_ready beats -> ddram_rd for 1 cycle, p0_dout_ready 128 pulses, p1_dout_ready 0, IDLE after beat 128.
2. p0 and p1 assert rd on the same cycle -> p0 granted, p1_busy=1 throughout; p1 is granted immediately after p0's last beat.
3. STARVE=4, p0 back-to-back write bursts of 4, p1 read pending -> 4 p0 grants, then p1 granted, starve_cnt reads 0 in st_dout.
4. p1 write burst of 8 with ddram_busy toggling every other cycle -> exactly 8 beats counted; ddram_din order matches p1_din at accepted cycles only.
5. p0 read burstcnt=0 -> treated as 1 beat; st_dout[7] at st_addr 0 = 1 until reset.
6. rst_n low for 1 cycle in the middle of a READ at beat 50 -> ddram_rd/we=0, both busy=1 during reset; IDLE afterwards; remaining dout_ready beats are not forwarded.
